jtkunio_colmix: RTL and testbench

Colour mixer at the back of the video path. Each pixel it takes the character-layer pixel from the char layer, the scroll-layer pixel and the object pixel, picks the winner by fixed priority and looks it up in a CPU-writable 12-bit palette RAM. It delays blanking to match the lookup and drives RGB to the frame video output.

---
 rtl/jtkunio_pkg.sv | 15 +
 rtl/jtkunio_colmix_if.sv | 13 +
 rtl/jtframe_dual_ram16.sv | 28 ++
 rtl/jtkunio_colmix_prio.sv | 38 +++
 rtl/jtkunio_colmix.sv | 109 ++++++++++
 tb/tb_jtkunio_colmix.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/jtkunio_pkg.sv
// Shared constants for the Kunio colour mixer: palette bank bases and the
// transparent colour code. Optional layer enables: JTKUNIO_GFXEN_EN.
package jtkunio_pkg;

    localparam logic [7:0] CHAR_BASE   = 8'h00;
    localparam logic [7:0] OBJ_BASE    = 8'h40;
    localparam logic [7:0] SCR_BASE    = 8'h80;
    localparam logic [3:0] TRANSP_COL  = 4'h0;
    localparam int         PIPE_STAGES = 3;

    function automatic logic is_opaque(input logic [3:0] col);
        return col != TRANSP_COL;
    endfunction

endpackage

// File: rtl/jtkunio_colmix_if.sv
// CPU palette bus of the colour mixer. The CPU side has no wait states:
// a write (pal_cs & ~cpu_wrn) lands on the clk edge; cpu_din is valid one clk
// after cpu_addr is stable. There is no valid/ready pair on this bus.
interface jtkunio_colmix_if;
    logic [8:0] cpu_addr;
    logic       pal_cs;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] cpu_din;

    modport master (output cpu_addr, pal_cs, cpu_wrn, cpu_dout, input cpu_din);
    modport slave  (input cpu_addr, pal_cs, cpu_wrn, cpu_dout, output cpu_din);
endinterface

// File: rtl/jtframe_dual_ram16.sv
// Dual-port 16-bit RAM: port 0 read/write with byte enables, port 1 read-only
// with a read enable so a held output stays put between enables.
module jtframe_dual_ram16 #(
    parameter int aw = 8
) (
    input  logic          clk0,
    input  logic [15:0]   data0,
    input  logic [aw-1:0] addr0,
    input  logic [1:0]    we0,
    output logic [15:0]   q0,
    input  logic          clk1,
    input  logic          cen1,
    input  logic [aw-1:0] addr1,
    output logic [15:0]   q1
);
    logic [15:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk0) begin
        if (we0[0]) mem[addr0][7:0]  <= data0[7:0];
        if (we0[1]) mem[addr0][15:8] <= data0[15:8];
        q0 <= mem[addr0];
    end

    // Read-before-write: a same-edge write from port 0 is seen next enable.
    always_ff @(posedge clk1) begin
        if (cen1) q1 <= mem[addr1];
    end
endmodule

// File: rtl/jtkunio_colmix_prio.sv
// Layer priority and palette index builder: char > obj > scroll.
// With JTKUNIO_GFXEN_EN each layer can be forced transparent by gfx_en.
module jtkunio_colmix_prio
    import jtkunio_pkg::*;
(
`ifdef JTKUNIO_GFXEN_EN
    input  logic [2:0] gfx_en,
`endif
    input  logic [4:0] char_pxl,
    input  logic [5:0] obj_pxl,
    input  logic [6:0] scr_pxl,
    output logic [7:0] idx
);
    logic char_en;
    logic scr_en;
    logic obj_en;

`ifdef JTKUNIO_GFXEN_EN
    assign char_en = gfx_en[0];
    assign scr_en  = gfx_en[1];
    assign obj_en  = gfx_en[2];
`else
    assign char_en = 1'b1;
    assign scr_en  = 1'b1;
    assign obj_en  = 1'b1;
`endif

    // Scroll is never transparent, so index 0 only appears when it is disabled.
    always_comb begin
        idx = 8'h00;
        if (char_en && is_opaque({1'b0, char_pxl[2:0]}))
            idx = CHAR_BASE | {3'b000, char_pxl};
        else if (obj_en && is_opaque(obj_pxl[3:0]))
            idx = OBJ_BASE | {2'b00, obj_pxl};
        else if (scr_en)
            idx = SCR_BASE | {1'b0, scr_pxl};
    end
endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: priority select, 12-bit palette lookup, blank-aligned RGB.
// Optional macro JTKUNIO_GFXEN_EN adds the gfx_en layer-enable input.
module jtkunio_colmix
    import jtkunio_pkg::*;
#(
    parameter int PALW = 8,
    parameter int LAT  = 3
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              pxl_cen,
`ifdef JTKUNIO_GFXEN_EN
    input  logic [2:0]        gfx_en,
`endif
    input  logic              LHBL,
    input  logic              LVBL,
    input  logic [4:0]        char_pxl,
    input  logic [5:0]        obj_pxl,
    input  logic [6:0]        scr_pxl,
    jtkunio_colmix_if.slave   cpu,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              LHBL_dly,
    output logic              LVBL_dly
);
    if (LAT != PIPE_STAGES) begin : g_bad_lat
        $error("jtkunio_colmix: LAT must equal the 3-stage pipeline");
    end

    logic [PALW-1:0] prio_idx;
    logic [PALW-1:0] idx_s1;
    logic            hbl_s1, vbl_s1;
    logic            hbl_s2, vbl_s2;
    logic [15:0]     pal_q;
    logic [15:0]     cpu_q;
    logic [15:0]     cpu_wdata;
    logic [1:0]      cpu_we;
    logic            cpu_wr;
    logic [3:0]      unused_pal;

    jtkunio_colmix_prio u_prio (
`ifdef JTKUNIO_GFXEN_EN
        .gfx_en   (gfx_en),
`endif
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .idx      (prio_idx)
    );

    // Even byte is {G,R}; odd byte is {0,B} so the upper nibble reads back 0.
    assign cpu_wr    = cpu.pal_cs & ~cpu.cpu_wrn;
    assign cpu_we    = {cpu_wr & cpu.cpu_addr[0], cpu_wr & ~cpu.cpu_addr[0]};
    assign cpu_wdata = {4'h0, cpu.cpu_dout[3:0], cpu.cpu_dout};
    assign cpu.cpu_din = cpu.cpu_addr[0] ? cpu_q[15:8] : cpu_q[7:0];
    assign unused_pal  = pal_q[15:12];

    jtframe_dual_ram16 #(.aw(PALW)) u_pal (
        .clk0  (clk),
        .data0 (cpu_wdata),
        .addr0 (cpu.cpu_addr[PALW:1]),
        .we0   (cpu_we),
        .q0    (cpu_q),
        .clk1  (clk),
        .cen1  (pxl_cen),
        .addr1 (idx_s1),
        .q1    (pal_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_s1 <= '0;
            hbl_s1 <= 1'b0;
            vbl_s1 <= 1'b0;
            hbl_s2 <= 1'b0;
            vbl_s2 <= 1'b0;
        end else if (pxl_cen) begin
            idx_s1 <= prio_idx;
            hbl_s1 <= LHBL;
            vbl_s1 <= LVBL;
            hbl_s2 <= hbl_s1;
            vbl_s2 <= vbl_s1;
        end
    end

    // Blanking registers reset low, so RGB stays black until the pipe refills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red      <= 4'h0;
            green    <= 4'h0;
            blue     <= 4'h0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            LHBL_dly <= hbl_s2;
            LVBL_dly <= vbl_s2;
            if (hbl_s2 && vbl_s2) begin
                red   <= pal_q[3:0];
                green <= pal_q[7:4];
                blue  <= pal_q[11:8];
            end else begin
                red   <= 4'h0;
                green <= 4'h0;
                blue  <= 4'h0;
            end
        end
    end
endmodule

// File: tb/tb_jtkunio_colmix.sv
// Bench for jtkunio_colmix: directed pixels feed an expected queue that a
// separate monitor drains three pixel enables later.
module tb_jtkunio_colmix;
    logic       rst;
    logic       clk;
    logic       pxl_cen;
    logic       LHBL, LVBL;
    logic [4:0] char_pxl;
    logic [5:0] obj_pxl;
    logic [6:0] scr_pxl;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;
`ifdef JTKUNIO_GFXEN_EN
    logic [2:0] gfx_en;
    logic [2:0] gfx_sel;
`endif

    logic        pix_chk;
    logic [13:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;
    logic        c1, c2, c3;

    jtkunio_colmix_if cpu_bus ();

    jtkunio_colmix #(.PALW(8), .LAT(3)) dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
`ifdef JTKUNIO_GFXEN_EN
        .gfx_en   (gfx_en),
`endif
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .cpu      (cpu_bus),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    // Clock and pixel enable (one enable every other clk)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pxl_cen = 1'b0;
        forever begin
            @(negedge clk);
            pxl_cen = ~pxl_cen;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [13:0] px(input logic hb, input logic vb, input logic [11:0] rgb);
        return {hb, vb, rgb};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cen();
        do @(posedge clk); while (pxl_cen !== 1'b1);
    endtask

    // Driver tasks
    task automatic drive_pixel(input logic [4:0] c, input logic [5:0] o, input logic [6:0] s,
                               input logic hb, input logic vb, input logic chk,
                               input logic [13:0] exp, input string nm);
        wait_cen();
        #1;
        char_pxl = c;
        obj_pxl  = o;
        scr_pxl  = s;
        LHBL     = hb;
        LVBL     = vb;
        pix_chk  = chk;
`ifdef JTKUNIO_GFXEN_EN
        gfx_en   = gfx_sel;
`endif
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
    endtask

    task automatic idle_pixel();
        drive_pixel(5'h00, 6'h00, 7'h00, 1'b1, 1'b1, 1'b0, 14'h0, "idle");
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_bus.cpu_addr = a;
        cpu_bus.cpu_dout = d;
        cpu_bus.pal_cs   = 1'b1;
        cpu_bus.cpu_wrn  = 1'b0;
        @(posedge clk);
        #1;
        cpu_bus.pal_cs   = 1'b0;
        cpu_bus.cpu_wrn  = 1'b1;
    endtask

    task automatic cpu_read(input logic [8:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        cpu_bus.cpu_addr = a;
        cpu_bus.pal_cs   = 1'b1;
        cpu_bus.cpu_wrn  = 1'b1;
        @(posedge clk);
        #1;
        check(nm, {8'h00, cpu_bus.cpu_din}, {8'h00, exp});
        cpu_bus.pal_cs   = 1'b0;
    endtask

    // Monitor: a pixel captured at enable m appears on the outputs at m+2
    initial begin
        c1 = 1'b0;
        c2 = 1'b0;
        c3 = 1'b0;
        forever begin
            wait_cen();
            c3 = c2;
            c2 = c1;
            c1 = pix_chk;
            if (c3) begin
                #2;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL underflow: output with no expected entry");
                end else begin
                    check(name_q.pop_front(), {2'b00, LHBL_dly, LVBL_dly, red, green, blue},
                          {2'b00, exp_q.pop_front()});
                end
            end
        end
    end

    // Stimulus
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        char_pxl = 5'h00;
        obj_pxl  = 6'h00;
        scr_pxl  = 7'h00;
        pix_chk  = 1'b0;
        cpu_bus.cpu_addr = 9'h000;
        cpu_bus.pal_cs   = 1'b0;
        cpu_bus.cpu_wrn  = 1'b1;
        cpu_bus.cpu_dout = 8'h00;
`ifdef JTKUNIO_GFXEN_EN
        gfx_sel = 3'b111;
        gfx_en  = 3'b111;
`endif
        repeat (4) @(posedge clk);
        #2;
        check("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
        check("rst_lhbl_dly", {15'h0, LHBL_dly}, 16'h0000);
        check("rst_lvbl_dly", {15'h0, LVBL_dly}, 16'h0000);
        @(negedge clk) rst = 1'b0;

        // Palette: entry = {B at odd byte, G/R at even byte}
        cpu_write(9'h000, 8'h5A);
        cpu_write(9'h001, 8'h0C);
        cpu_read(9'h000, 8'h5A, "rd_even");
        cpu_read(9'h001, 8'h0C, "rd_odd");
        cpu_write(9'h012, 8'h21);
        cpu_write(9'h013, 8'h03);
        cpu_write(9'h0A6, 8'h54);
        cpu_write(9'h0A7, 8'h06);
        cpu_write(9'h144, 8'h87);
        cpu_write(9'h145, 8'hF9);
        cpu_read(9'h145, 8'h09, "rd_odd_nibble");
        cpu_read(9'h012, 8'h21, "rd_entry09");

        // Priority and blanking
        drive_pixel(5'h09, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h123), "prio_char");
        drive_pixel(5'h08, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h456), "prio_obj");
        drive_pixel(5'h10, 6'h20, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h789), "prio_scr");
        drive_pixel(5'h09, 6'h13, 7'h22, 1'b0, 1'b1, 1'b1, px(1'b0, 1'b1, 12'h000), "hblank");
        drive_pixel(5'h09, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h123), "hblank_end");
        drive_pixel(5'h08, 6'h13, 7'h22, 1'b1, 1'b0, 1'b1, px(1'b1, 1'b0, 12'h000), "vblank");
        drive_pixel(5'h08, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h456), "vblank_end");

        // Collision on entry 0xA2: write lands on the enable where the first pixel reads it
        fork
            begin
                drive_pixel(5'h00, 6'h00, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h789), "collide_old");
                drive_pixel(5'h00, 6'h00, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'hDE9), "collide_new");
                idle_pixel();
            end
            begin
                wait_cen();
                wait_cen();
                @(posedge clk);
                #1;
                cpu_bus.cpu_addr = 9'h144;
                cpu_bus.cpu_dout = 8'hED;
                cpu_bus.pal_cs   = 1'b1;
                cpu_bus.cpu_wrn  = 1'b0;
                @(posedge clk);
                #1;
                cpu_bus.pal_cs   = 1'b0;
                cpu_bus.cpu_wrn  = 1'b1;
            end
        join

        // Reset in mid-frame with a visible colour on the outputs
        repeat (4) drive_pixel(5'h09, 6'h13, 7'h22, 1'b1, 1'b1, 1'b0, 14'h0, "fill");
        wait_cen();
        #2;
        check("pre_rst_rgb", {4'h0, red, green, blue}, 16'h0123);
        #1 rst = 1'b1;
        #1;
        check("midrst_rgb", {4'h0, red, green, blue}, 16'h0000);
        check("midrst_lhbl_dly", {15'h0, LHBL_dly}, 16'h0000);
        check("midrst_lvbl_dly", {15'h0, LVBL_dly}, 16'h0000);
        repeat (3) @(posedge clk);
        wait_cen();
        #3 rst = 1'b0;
        wait_cen();
        #2;
        check("refill_cen1", {2'b00, LHBL_dly, LVBL_dly, red, green, blue}, 16'h0000);
        wait_cen();
        #2;
        check("refill_cen2", {2'b00, LHBL_dly, LVBL_dly, red, green, blue}, 16'h0000);
        wait_cen();
        #2;
        check("refill_cen3", {2'b00, LHBL_dly, LVBL_dly, red, green, blue}, {2'b00, px(1'b1, 1'b1, 12'h123)});

`ifdef JTKUNIO_GFXEN_EN
        gfx_sel = 3'b110;
        drive_pixel(5'h09, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'h456), "gfx_char_off");
        gfx_sel = 3'b000;
        drive_pixel(5'h09, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'hA5C), "gfx_all_off");
        gfx_sel = 3'b101;
        drive_pixel(5'h08, 6'h20, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'hA5C), "gfx_scr_off");
        gfx_sel = 3'b011;
        drive_pixel(5'h08, 6'h13, 7'h22, 1'b1, 1'b1, 1'b1, px(1'b1, 1'b1, 12'hDE9), "gfx_obj_off");
        gfx_sel = 3'b111;
`endif

        repeat (5) idle_pixel();
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
